n101_reg_vec_ctl: RTL and testbench

Parametrised control/status register vector: successor to the fixed 32-bit, enable-only register vector used in the peripheral blocks. Adds configurable width and reset value, byte strobes, four software write modes, sticky hardware event bits, a one-shot lock and a per-bit change mask. Sits between a peripheral's register-bus decode and its datapath; one instance per CSR.

---
 rtl/n101_reg_vec_ctl_if.sv | 34 +++
 rtl/n101_reg_vec_ctl.sv | 103 ++++++++++
 tb/tb_n101_reg_vec_ctl.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/n101_reg_vec_ctl_if.sv
// ---------------------------------------------------------------------------
// n101_reg_vec_ctl_if
// Bus bundle for one control/status register instance.
//   master : register-bus decode / hardware side. It drives the write
//            request, data, strobes and mode, plus the hardware event bits
//            and the lock request. It observes the register value, the
//            change mask and the lock state.
//   slave  : the register vector itself.
// ---------------------------------------------------------------------------
interface n101_reg_vec_ctl_if #(
    parameter int WIDTH = 32
);
    localparam int NSTRB = (WIDTH + 7) / 8;

    logic             io_en;
    logic [WIDTH-1:0] io_d;
    logic [NSTRB-1:0] io_strb;
    logic [1:0]       io_mode;
    logic [WIDTH-1:0] io_hw_set;
    logic             io_lock;
    logic [WIDTH-1:0] io_q;
    logic [WIDTH-1:0] io_chg;
    logic             io_locked;

    modport master (
        output io_en, io_d, io_strb, io_mode, io_hw_set, io_lock,
        input  io_q, io_chg, io_locked
    );

    modport slave (
        input  io_en, io_d, io_strb, io_mode, io_hw_set, io_lock,
        output io_q, io_chg, io_locked
    );
endinterface

// File: rtl/n101_reg_vec_ctl.sv
// ---------------------------------------------------------------------------
// n101_reg_vec_ctl
// Parametrised control/status register with byte strobes, four software
// write modes (WRITE / W1C / W1S / W1T), sticky hardware set bits, an
// optional one-shot software-write lock and a registered per-bit change mask.
//
// Ports
//   clock : sole clock, every state update happens on its rising edge
//   reset : synchronous active-high reset
//   bus   : slave side of n101_reg_vec_ctl_if
//           inputs  io_en, io_d, io_strb, io_mode, io_hw_set, io_lock
//           outputs io_q, io_chg, io_locked (all registered)
// ---------------------------------------------------------------------------
module n101_reg_vec_ctl #(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VAL   = '0,
    parameter logic [WIDTH-1:0] HW_SET_MASK = '0,
    parameter bit               LOCK_EN     = 1'b0
) (
    input  logic                      clock,
    input  logic                      reset,
    n101_reg_vec_ctl_if.slave         bus
);
    localparam int NSTRB = (WIDTH + 7) / 8;

    localparam logic [1:0] MODE_WRITE = 2'd0;
    localparam logic [1:0] MODE_W1C   = 2'd1;
    localparam logic [1:0] MODE_W1S   = 2'd2;
    localparam logic [1:0] MODE_W1T   = 2'd3;

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] chg_reg;
    logic             locked_reg;

    logic             sw_ok;
    logic [WIDTH-1:0] wr_mask;
    logic [WIDTH-1:0] sw_val;
    logic [WIDTH-1:0] sw_next;

    // Software may touch the register only while unlocked; a write issued in
    // the same cycle as the lock request still lands because locked_reg only
    // rises on that edge.
    assign sw_ok = bus.io_en & ~locked_reg;

    // Expand byte strobes to a per-bit mask; the last strobe is clipped to
    // WIDTH-1 simply by not generating bits above it.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_wr_mask
            assign wr_mask[gi] = sw_ok & bus.io_strb[gi / 8];
        end
    endgenerate

    always_comb begin
        sw_val = bus.io_d;
        unique case (bus.io_mode)
            MODE_WRITE: sw_val = bus.io_d;
            MODE_W1C:   sw_val = q_reg & ~bus.io_d;
            MODE_W1S:   sw_val = q_reg | bus.io_d;
            MODE_W1T:   sw_val = q_reg ^ bus.io_d;
            default:    sw_val = bus.io_d;
        endcase
    end

    // Hardware set is OR-ed in last so an event always beats a same-cycle
    // software clear, zero write or toggle; it is not gated by the lock.
    always_comb begin
        sw_next = (q_reg & ~wr_mask) | (sw_val & wr_mask);
        q_next  = sw_next | (bus.io_hw_set & HW_SET_MASK);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            q_reg   <= RESET_VAL;
            chg_reg <= '0;
        end else begin
            q_reg   <= q_next;
            chg_reg <= q_next ^ q_reg;
        end
    end

    generate
        if (LOCK_EN) begin : g_lock
            // One-shot: once set, only reset clears it.
            always_ff @(posedge clock) begin
                if (reset) begin
                    locked_reg <= 1'b0;
                end else if (bus.io_lock) begin
                    locked_reg <= 1'b1;
                end
            end
        end else begin : g_no_lock
            always_ff @(posedge clock) begin
                locked_reg <= 1'b0;
            end
        end
    endgenerate

    assign bus.io_q      = q_reg;
    assign bus.io_chg    = chg_reg;
    assign bus.io_locked = locked_reg;

endmodule

// File: tb/tb_n101_reg_vec_ctl.sv
// ---------------------------------------------------------------------------
// tb_n101_reg_vec_ctl
// Directed bench for n101_reg_vec_ctl. Two instances:
//   A : WIDTH=32, RESET_VAL=0xA5, HW_SET_MASK=0x1, LOCK_EN=1
//   B : WIDTH=12, RESET_VAL=0x5A3, HW_SET_MASK=0x800, LOCK_EN=0
// Expected values are hand-computed constants in the stimulus below.
// ---------------------------------------------------------------------------
module tb_n101_reg_vec_ctl;
    logic clock = 1'b0;
    logic reset_a;
    logic reset_b;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clock = ~clock;

    n101_reg_vec_ctl_if #(.WIDTH(32)) bus_a ();
    n101_reg_vec_ctl_if #(.WIDTH(12)) bus_b ();

    n101_reg_vec_ctl #(
        .WIDTH      (32),
        .RESET_VAL  (32'h0000_00A5),
        .HW_SET_MASK(32'h0000_0001),
        .LOCK_EN    (1'b1)
    ) dut_a (
        .clock(clock),
        .reset(reset_a),
        .bus  (bus_a.slave)
    );

    n101_reg_vec_ctl #(
        .WIDTH      (12),
        .RESET_VAL  (12'h5A3),
        .HW_SET_MASK(12'h800),
        .LOCK_EN    (1'b0)
    ) dut_b (
        .clock(clock),
        .reset(reset_b),
        .bus  (bus_b.slave)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Advance one edge and sample 1 time unit after it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_a(input logic en, input logic [31:0] d, input logic [3:0] strb,
                           input logic [1:0] mode, input logic [31:0] hw, input logic lock);
        bus_a.io_en     = en;
        bus_a.io_d      = d;
        bus_a.io_strb   = strb;
        bus_a.io_mode   = mode;
        bus_a.io_hw_set = hw;
        bus_a.io_lock   = lock;
    endtask

    task automatic drive_b(input logic en, input logic [11:0] d, input logic [1:0] strb,
                           input logic [1:0] mode, input logic [11:0] hw, input logic lock);
        bus_b.io_en     = en;
        bus_b.io_d      = d;
        bus_b.io_strb   = strb;
        bus_b.io_mode   = mode;
        bus_b.io_hw_set = hw;
        bus_b.io_lock   = lock;
    endtask

    task automatic check_a(input string tag, input logic [31:0] q, input logic [31:0] chg,
                           input logic locked);
        check({tag, ".q"},      64'(bus_a.io_q),      64'(q));
        check({tag, ".chg"},    64'(bus_a.io_chg),    64'(chg));
        check({tag, ".locked"}, 64'(bus_a.io_locked), 64'(locked));
    endtask

    task automatic check_b(input string tag, input logic [11:0] q, input logic [11:0] chg,
                           input logic locked);
        check({tag, ".q"},      64'(bus_b.io_q),      64'(q));
        check({tag, ".chg"},    64'(bus_b.io_chg),    64'(chg));
        check({tag, ".locked"}, 64'(bus_b.io_locked), 64'(locked));
    endtask

    initial begin
        reset_a = 1'b1;
        reset_b = 1'b1;
        drive_a(1'b0, '0, '0, 2'd0, '0, 1'b0);
        drive_b(1'b0, '0, '0, 2'd0, '0, 1'b0);

        // ---------------- instance A ----------------
        tick();
        check_a("a_reset", 32'h0000_00A5, 32'h0, 1'b0);
        reset_a = 1'b0;

        drive_a(1'b1, 32'h1234_5678, 4'b0101, 2'd0, '0, 1'b0); tick();
        check_a("a_write_strb", 32'h0034_0078, 32'h0034_00DD, 1'b0);

        drive_a(1'b1, 32'hFF00_FF00, 4'hF, 2'd0, '0, 1'b0); tick();
        check_a("a_write_full", 32'hFF00_FF00, 32'hFF34_FF78, 1'b0);

        drive_a(1'b1, 32'h0F00_0F00, 4'hF, 2'd1, '0, 1'b0); tick();
        check_a("a_w1c", 32'hF000_F000, 32'h0F00_0F00, 1'b0);

        drive_a(1'b1, 32'h0000_000F, 4'hF, 2'd2, '0, 1'b0); tick();
        check_a("a_w1s", 32'hF000_F00F, 32'h0000_000F, 1'b0);

        drive_a(1'b1, 32'hFFFF_FFFF, 4'hF, 2'd3, '0, 1'b0); tick();
        check_a("a_w1t", 32'h0FFF_0FF0, 32'hFFFF_FFFF, 1'b0);

        drive_a(1'b1, 32'h0000_0000, 4'h0, 2'd0, '0, 1'b0); tick();
        check_a("a_nostrb", 32'h0FFF_0FF0, 32'h0, 1'b0);

        drive_a(1'b1, 32'h0FFF_0FF0, 4'hF, 2'd0, '0, 1'b0); tick();
        check_a("a_same_val", 32'h0FFF_0FF0, 32'h0, 1'b0);

        drive_a(1'b0, 32'hFFFF_FFFF, 4'hF, 2'd0, '0, 1'b0); tick();
        check_a("a_idle", 32'h0FFF_0FF0, 32'h0, 1'b0);

        drive_a(1'b1, 32'h0000_0001, 4'hF, 2'd0, '0, 1'b0); tick();
        check_a("a_set_one", 32'h0000_0001, 32'h0FFF_0FF1, 1'b0);

        drive_a(1'b1, 32'h0000_0001, 4'h1, 2'd1, 32'h1, 1'b0); tick();
        check_a("a_hw_vs_w1c", 32'h0000_0001, 32'h0, 1'b0);

        drive_a(1'b0, 32'h0, 4'h0, 2'd0, 32'h2, 1'b0); tick();
        check_a("a_hw_unmasked", 32'h0000_0001, 32'h0, 1'b0);

        drive_a(1'b1, 32'h0, 4'hF, 2'd0, 32'h1, 1'b0); tick();
        check_a("a_hw_vs_write0", 32'h0000_0001, 32'h0, 1'b0);

        drive_a(1'b1, 32'h1, 4'h1, 2'd3, 32'h1, 1'b0); tick();
        check_a("a_hw_vs_w1t", 32'h0000_0001, 32'h0, 1'b0);

        drive_a(1'b1, 32'h0, 4'hF, 2'd0, '0, 1'b0); tick();
        check_a("a_clear", 32'h0, 32'h1, 1'b0);

        drive_a(1'b0, 32'h0, 4'h0, 2'd0, 32'h1, 1'b0); tick();
        check_a("a_hw_set", 32'h1, 32'h1, 1'b0);

        drive_a(1'b1, 32'hAAAA_AAAA, 4'hF, 2'd0, '0, 1'b1); tick();
        check_a("a_lock_write", 32'hAAAA_AAAA, 32'hAAAA_AAAB, 1'b1);

        drive_a(1'b1, 32'h5555_5555, 4'hF, 2'd0, '0, 1'b0); tick();
        check_a("a_locked_write", 32'hAAAA_AAAA, 32'h0, 1'b1);

        drive_a(1'b0, 32'h0, 4'h0, 2'd0, 32'hFFFF_FFFF, 1'b0); tick();
        check_a("a_locked_hw", 32'hAAAA_AAAB, 32'h1, 1'b1);

        reset_a = 1'b1;
        drive_a(1'b1, 32'h5555_5555, 4'hF, 2'd0, '0, 1'b0); tick();
        check_a("a_reset_again", 32'h0000_00A5, 32'h0, 1'b0);
        reset_a = 1'b0;
        drive_a(1'b0, 32'h0, 4'h0, 2'd0, '0, 1'b0);

        // ---------------- instance B ----------------
        tick();
        check_b("b_reset", 12'h5A3, 12'h0, 1'b0);
        reset_b = 1'b0;

        drive_b(1'b1, 12'h000, 2'b11, 2'd0, '0, 1'b0); tick();
        check_b("b_clear", 12'h000, 12'h5A3, 1'b0);

        drive_b(1'b1, 12'hFFF, 2'b10, 2'd0, '0, 1'b0); tick();
        check_b("b_upper_strb", 12'hF00, 12'hF00, 1'b0);

        drive_b(1'b1, 12'h0AB, 2'b11, 2'd0, '0, 1'b1); tick();
        check_b("b_lock_ignored", 12'h0AB, 12'hFAB, 1'b0);

        drive_b(1'b1, 12'h123, 2'b01, 2'd0, '0, 1'b0); tick();
        check_b("b_lower_strb", 12'h023, 12'h088, 1'b0);

        drive_b(1'b0, 12'h000, 2'b00, 2'd0, 12'hFFF, 1'b0); tick();
        check_b("b_hw_mask", 12'h823, 12'h800, 1'b0);

        reset_b = 1'b1;
        drive_b(1'b1, 12'hFFF, 2'b11, 2'd0, '0, 1'b0); tick();
        check_b("b_reset_mid", 12'h5A3, 12'h0, 1'b0);
        reset_b = 1'b0;
        drive_b(1'b0, 12'h000, 2'b00, 2'd0, '0, 1'b0);

        tick();
        check_b("b_after_reset", 12'h5A3, 12'h0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
